// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the 6502 bus trace unit and its trace FIFO.
//   trace_rec_t : one captured bus cycle {cycle, sync, we, addr, data}
//   TRACE_W     : record width for the default cycle-stamp width
//   OVF_MAX     : saturation value of the dropped-record counter
//   bus_data()  : selects the byte actually moved on the bus this cycle
// -----------------------------------------------------------------------------
package trace_pkg;

  localparam int CYC_W_DEF = 16;
  localparam int TRACE_W   = CYC_W_DEF + 26;

  localparam logic [7:0] OVF_MAX = 8'd255;

  typedef struct packed {
    logic [CYC_W_DEF-1:0] cycle;
    logic                 sync;
    logic                 we;
    logic [15:0]          addr;
    logic [7:0]           data;
  } trace_rec_t;

  // Writes carry CPU data out, reads carry memory data in.
  function automatic logic [7:0] bus_data(input logic       we,
                                          input logic [7:0] dout,
                                          input logic [7:0] din);
    logic [7:0] sel;
    if (we) begin
      sel = dout;
    end else begin
      sel = din;
    end
    return sel;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Generic synchronous first-word-fall-through FIFO.
//   clk_i, rst_i : clock, synchronous active-high reset (pointers only)
//   push_i       : write data_i this edge (ignored when full without a pop)
//   pop_i        : retire the head this edge (ignored when empty)
//   data_o       : current head entry, valid whenever empty_o is 0
//   full_o       : DEPTH entries stored
//   empty_o      : no entries stored
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 42
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push
  // when the head is retired simultaneously; a pop on empty is ignored.
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Pointer next-state.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push_s) begin
      wr_d = wr_q + PTR_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + PTR_ONE;
    end else begin
      rd_d = rd_q;
    end
  end

  // Pointer registers; reset empties the FIFO regardless of contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are don't-care until pointed at by a valid head.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/bus_trace_unit.sv
// -----------------------------------------------------------------------------
// bus_trace_unit
// Passive observer of the 6502 external bus. Every completed bus cycle
// (i_rdy=1) becomes a trace record queued for a valid/ready consumer, and a
// repeated opcode fetch at one address raises a sticky trap flag.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_addr/i_dout/i_din    : bus address, CPU write data, memory read data
//   i_we, i_sync, i_rdy    : write strobe, opcode-fetch marker, cycle complete
//   o_trace_valid/_data    : FIFO head {cycle, sync, we, addr, data}
//   i_trace_ready          : consumer accepts the head
//   o_overflow             : saturating count of records dropped while full
//   o_trap, o_trap_pc      : sticky trap flag and the trapping fetch address
//   o_cycle                : completed-cycle counter (wraps)
// -----------------------------------------------------------------------------
module bus_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TRAP_REPEAT = 3,
  parameter int CYC_W       = CYC_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [15:0]       i_addr,
  input  logic [7:0]        i_dout,
  input  logic [7:0]        i_din,
  input  logic              i_we,
  input  logic              i_sync,
  input  logic              i_rdy,
  output logic              o_trace_valid,
  output logic [CYC_W+25:0] o_trace_data,
  input  logic              i_trace_ready,
  output logic [7:0]        o_overflow,
  output logic              o_trap,
  output logic [15:0]       o_trap_pc,
  output logic [CYC_W-1:0]  o_cycle
);

  localparam int REC_W = CYC_W + 26;
  localparam int CNT_W = $clog2(TRAP_REPEAT + 1);
  localparam logic [CNT_W-1:0] TRAP_CNT = CNT_W'(TRAP_REPEAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};

  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [7:0]       ovf_q, ovf_d;
  logic             trap_q, trap_d;
  logic [15:0]      trap_pc_q, trap_pc_d;
  logic [15:0]      last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [REC_W-1:0] rec_s;
  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             drop_s;
  logic             fetch_s;

  assign rec_s   = {cycle_q, i_sync, i_we, i_addr, bus_data(i_we, i_dout, i_din)};
  assign pop_s   = o_trace_valid && i_trace_ready;
  assign drop_s  = i_rdy && full_s && !pop_s;
  assign fetch_s = i_rdy && i_sync;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (i_rdy),
    .data_i  (rec_s),
    .pop_i   (pop_s),
    .data_o  (o_trace_data),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign o_trace_valid = !empty_s;
  assign o_overflow    = ovf_q;
  assign o_trap        = trap_q;
  assign o_trap_pc     = trap_pc_q;
  assign o_cycle       = cycle_q;

  // Cycle stamp and dropped-record counter next-state.
  always_comb begin
    cycle_d = cycle_q;
    ovf_d   = ovf_q;
    if (i_rdy) begin
      cycle_d = cycle_q + CYC_ONE;
    end else begin
      cycle_d = cycle_q;
    end
    if (drop_s && (ovf_q != OVF_MAX)) begin
      ovf_d = ovf_q + 8'd1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Repeat tracking over opcode fetches only; the trap latches on the fetch
  // that brings the run length up to TRAP_REPEAT and is frozen afterwards.
  always_comb begin
    last_d    = last_q;
    cnt_d     = cnt_q;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;
    if (fetch_s) begin
      if (i_addr == last_q) begin
        if (cnt_q == TRAP_CNT) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        cnt_d  = CNT_ONE;
        last_d = i_addr;
      end
    end else begin
      cnt_d  = cnt_q;
      last_d = last_q;
    end
    if (!trap_q && fetch_s && (cnt_d == TRAP_CNT)) begin
      trap_d    = 1'b1;
      trap_pc_d = i_addr;
    end else begin
      trap_d    = trap_q;
      trap_pc_d = trap_pc_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_q   <= '0;
      ovf_q     <= 8'd0;
      trap_q    <= 1'b0;
      trap_pc_q <= 16'h0000;
      last_q    <= 16'h0000;
      cnt_q     <= '0;
    end else begin
      cycle_q   <= cycle_d;
      ovf_q     <= ovf_d;
      trap_q    <= trap_d;
      trap_pc_q <= trap_pc_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_trace_unit.sv
// -----------------------------------------------------------------------------
// tb_bus_trace_unit
// Directed scenarios followed by randomized traffic. The stimulus side keeps a
// behavioural model (record queue, occupancy, counters, fetch history) and a
// negedge monitor compares the presented FIFO head against the queue.
// -----------------------------------------------------------------------------
module tb_bus_trace_unit;
  import trace_pkg::*;

  localparam int DEPTH       = 16;
  localparam int TRAP_REPEAT = 3;
  localparam int CYC_W       = 16;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [15:0]       i_addr = 16'h0000;
  logic [7:0]        i_dout = 8'h00;
  logic [7:0]        i_din = 8'h00;
  logic              i_we = 1'b0;
  logic              i_sync = 1'b0;
  logic              i_rdy = 1'b0;
  logic              o_trace_valid;
  logic [CYC_W+25:0] o_trace_data;
  logic              i_trace_ready = 1'b0;
  logic [7:0]        o_overflow;
  logic              o_trap;
  logic [15:0]       o_trap_pc;
  logic [CYC_W-1:0]  o_cycle;

  bus_trace_unit #(.DEPTH(DEPTH), .TRAP_REPEAT(TRAP_REPEAT), .CYC_W(CYC_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_dout(i_dout), .i_din(i_din),
    .i_we(i_we), .i_sync(i_sync), .i_rdy(i_rdy), .o_trace_valid(o_trace_valid),
    .o_trace_data(o_trace_data), .i_trace_ready(i_trace_ready), .o_overflow(o_overflow),
    .o_trap(o_trap), .o_trap_pc(o_trap_pc), .o_cycle(o_cycle)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  trace_rec_t  exp_q[$];
  logic [15:0] fetch_hist[$];
  int          model_occ = 0;
  int          exp_cycle = 0;
  int          exp_ovf = 0;
  bit          exp_trap = 1'b0;
  logic [15:0] exp_pc = 16'h0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: head must match model head whenever valid; retire on handshake.
  always @(negedge i_clk) begin
    if (!i_rst && o_trace_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL trace_unexpected: got %0h, required no record", o_trace_data);
      end else begin
        if (o_trace_data !== exp_q[0]) begin
          errors++;
          $display("FAIL trace_data: got %0h, required %0h", o_trace_data, exp_q[0]);
        end
        if (i_trace_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_cycle"}, 64'(o_cycle), 64'(exp_cycle));
    check({tag, "_overflow"}, 64'(o_overflow), 64'(exp_ovf));
    check({tag, "_trap"}, 64'(o_trap), 64'(exp_trap));
    check({tag, "_trap_pc"}, 64'(o_trap_pc), 64'(exp_pc));
    check({tag, "_valid"}, 64'(o_trace_valid), 64'(model_occ > 0));
  endtask

  // One bus clock: drive, update model for the coming edge, then check.
  task automatic cyc(input logic rdy, input logic sync, input logic we,
                     input logic [15:0] addr, input logic [7:0] dout,
                     input logic [7:0] din, input logic ready);
    trace_rec_t r;
    int         p;
    bit         same;
    i_rdy = rdy; i_sync = sync; i_we = we; i_addr = addr;
    i_dout = dout; i_din = din; i_trace_ready = ready;
    p = (ready && model_occ > 0) ? 1 : 0;
    model_occ = model_occ - p;
    if (rdy) begin
      r.cycle = 16'(exp_cycle);
      r.sync  = sync;
      r.we    = we;
      r.addr  = addr;
      r.data  = we ? dout : din;
      if (model_occ < DEPTH) begin
        exp_q.push_back(r);
        model_occ++;
      end else if (exp_ovf < 255) begin
        exp_ovf++;
      end
      exp_cycle = (exp_cycle + 1) % (1 << CYC_W);
      if (sync) begin
        fetch_hist.push_back(addr);
        if (fetch_hist.size() > TRAP_REPEAT) void'(fetch_hist.pop_front());
        same = (fetch_hist.size() == TRAP_REPEAT);
        foreach (fetch_hist[k]) if (fetch_hist[k] != addr) same = 1'b0;
        if (!exp_trap && same) begin
          exp_trap = 1'b1;
          exp_pc   = addr;
        end
      end
    end
    @(posedge i_clk); #1;
    check_state("cyc");
  endtask

  task automatic do_reset(input logic rdy_during);
    i_rst = 1'b1; i_rdy = rdy_during; i_sync = 1'b1; i_trace_ready = 1'b1;
    exp_q.delete(); fetch_hist.delete();
    model_occ = 0; exp_cycle = 0; exp_ovf = 0; exp_trap = 1'b0; exp_pc = 16'h0000;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check_state("reset");
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, ready);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    int          s;
    repeat (2) @(posedge i_clk);
    #1;
    do_reset(1'b0);

    // Read then write stream
    cyc(1'b1, 1'b0, 1'b0, 16'hFFFC, 8'h3C, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 16'h0200, 8'hA5, 8'h77, 1'b1);
    idle(3, 1'b1);
    check("rw_cycle_is_2", 64'(o_cycle), 64'd2);

    // Wait states between two cycles
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 8'h11, 1'b1);
    idle(3, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 16'h1235, 8'h22, 8'h00, 1'b1);
    idle(3, 1'b1);

    // Overflow, full push+pop, then saturation
    do_reset(1'b0);
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'b0, 1'b0, 16'(16'h3000 + i), 8'h00, 8'(i), 1'b0);
    check("ovf_is_4", 64'(o_overflow), 64'd4);
    cyc(1'b1, 1'b0, 1'b1, 16'h3100, 8'h5A, 8'h00, 1'b1);
    check("ovf_full_pushpop", 64'(o_overflow), 64'd4);
    for (int i = 0; i < 300; i++)
      cyc(1'b1, 1'b0, 1'b0, 16'h3200, 8'h00, 8'h01, 1'b0);
    check("ovf_saturated", 64'(o_overflow), 64'd255);
    idle(DEPTH + 2, 1'b1);

    // Trap detection with interleaved non-sync cycles
    do_reset(1'b0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0400, 8'h00, 8'h4C, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0401, 8'h00, 8'h03, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0403, 8'h00, 8'h4C, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0404, 8'h00, 8'h03, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 16'h0403, 8'h00, 8'h4C, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 16'h01FF, 8'h99, 8'h00, 1'b1);
    check("trap_not_yet", 64'(o_trap), 64'd0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0403, 8'h00, 8'h4C, 1'b1);
    check("trap_set", 64'(o_trap), 64'd1);
    check("trap_pc", 64'(o_trap_pc), 64'h0403);
    cyc(1'b1, 1'b1, 1'b0, 16'h0500, 8'h00, 8'hEA, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0600, 8'h00, 8'hEA, 1'b1);
    check("trap_pc_held", 64'(o_trap_pc), 64'h0403);
    idle(4, 1'b1);

    // Reset mid-operation with records queued and trap set
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0700, 8'h00, 8'(i), 1'b0);
    check("mid_trap", 64'(o_trap), 64'd1);
    do_reset(1'b1);
    cyc(1'b1, 1'b0, 1'b1, 16'h0800, 8'hC3, 8'h00, 1'b0);
    check("post_reset_stamp", 64'(o_trace_data[CYC_W+25:26]), 64'd0);
    idle(3, 1'b1);

    // Randomized traffic
    do_reset(1'b0);
    for (int i = 0; i < 800; i++) begin
      s = $urandom_range(0, 3);
      a = (s == 0) ? 16'h0400 : (s == 1) ? 16'h0401 : 16'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          a, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0));
      if (i == 400) do_reset(1'($urandom_range(0, 1)));
    end
    idle(DEPTH + 2, 1'b1);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_trace_unit.md
Name: bus_trace_unit

Overview:
- Passive observer on the 6502 core's external bus, sitting directly downstream of the CPU top inside the simulation/FPGA harness.
- Captures every completed bus cycle into a trace FIFO that is drained by a valid/ready consumer (bench logger or UART formatter).
- Detects the "jump-to-self" trap, where the same PC is fetched repeatedly, and raises a sticky flag so benches and hardware stop on program completion instead of a fixed timeout.

Parameters:
- DEPTH, 16, trace FIFO entries; power of two, at least 2.
- TRAP_REPEAT, 3, number of consecutive opcode fetches at an identical address that declares a trap; at least 2.
- CYC_W, 16, width of the free-running cycle stamp.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_addr  in  16  CPU address bus
- i_dout  in  8  CPU write data
- i_din  in  8  memory read data returned to the CPU
- i_we  in  1  CPU write strobe (1 = write)
- i_sync  in  1  opcode-fetch cycle marker
- i_rdy  in  1  bus cycle completes this clock (0 = wait state)
- o_trace_valid  out  1  FIFO head valid
- o_trace_data  out  CYC_W+26  head record {cycle, sync, we, addr, data}
- i_trace_ready  in  1  consumer accepts the head
- o_overflow  out  8  count of dropped records, saturating
- o_trap  out  1  sticky trap detected
- o_trap_pc  out  16  address of the trapping fetch
- o_cycle  out  CYC_W  completed-cycle counter

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: o_trace_valid=0, FIFO empty (pointers 0), o_overflow=0, o_trap=0, o_trap_pc=0, o_cycle=0, repeat counter 0, last-fetch register 0.
- Reset asserted mid-stream discards all FIFO contents; no partial record survives.
- Capture:
  - On a clock edge with i_rdy=1, build a record: cycle=o_cycle (pre-increment value), sync=i_sync, we=i_we, addr=i_addr.
  - data = i_dout when i_we=1, otherwise i_din.
  - o_cycle increments on the same edge and wraps modulo 2^CYC_W.
  - i_rdy=0: no record, no increment.
- Latency: a record captured at edge N appears on o_trace_valid/o_trace_data after edge N, i.e. visible in cycle N+1 when the FIFO was empty.
- FIFO behaviour:
  - Head output is first-word fall-through.
  - Pop occurs when o_trace_valid and i_trace_ready are both 1.
  - o_trace_data is stable while valid=1 and ready=0.
- Full FIFO:
  - A push with no simultaneous pop is dropped, and o_overflow increments, saturating at 255.
  - Push and pop on the same edge while full: both succeed, no drop.
- Empty FIFO: ready with valid=0 has no effect. Push and pop on the same edge while empty: the push is stored and the pop is ignored.
- Pointers: log2(DEPTH)+1 bits with a wrap bit. full = MSBs differ and the low bits are equal. empty = pointers equal.
- Trap detection, evaluated only on cycles with i_rdy=1 and i_sync=1:
  - If i_addr equals the last-fetch register, the repeat count increments, saturating. Otherwise the count is set to 1 and the last-fetch register is loaded with i_addr.
  - When the count reaches TRAP_REPEAT, o_trap is set and o_trap_pc is set to i_addr on the same edge.
  - o_trap and o_trap_pc then hold until reset, and later fetches do not change them.
- Capture continues after a trap.
- Non-sync cycles do not disturb the repeat state.

Decomposition:
- Package trace_pkg holds:
  - the trace_rec_t packed struct (cycle, sync, we, addr, data);
  - the localparam TRACE_W derived from CYC_W;
  - the OVF_MAX constant (255).
- Sub-module trace_fifo: a generic synchronous FWFT FIFO, parameterised by DEPTH and width, exposing full and empty. It is reusable for the later UART formatter.
- Trap detector and capture logic live in bus_trace_unit.

Test Plan:
- Read then write stream: reset, then i_rdy=1 for two cycles.
  - Cycle 0 stimulus: addr=FFFC, we=0, din=00. Cycle 1 stimulus: addr=0200, we=1, dout=A5.
  - Consumer always ready. Required: records {0,0,0,FFFC,00} then {1,0,1,0200,A5}, and o_cycle=2.
- Wait states: i_rdy low for 3 clocks between two cycles.
  - Required: exactly 2 records with cycle stamps 0 and 1, and o_cycle unchanged across the stalls.
- Overflow: consumer held not-ready for 20 ready cycles with DEPTH=16.
  - Required: 16 records retained with stamps 0..15, o_overflow=4, o_trace_data held at stamp 0 throughout.
  - Then push and pop on the same cycle while full: no drop, o_overflow stays 4.
- Saturation: 300 drops while full. Required: o_overflow=255.
- Trap: sync fetches at 0400, 0403, 0403, 0403 with non-sync cycles interleaved.
  - Required: o_trap rises on the edge of the third 0403 fetch, o_trap_pc=0403.
  - A later fetch at 0500 leaves o_trap=1 and o_trap_pc=0403.
- Reset mid-operation: 5 records queued and o_trap set, then i_rst for 1 clock.
  - Required: next cycle o_trace_valid=0, o_trap=0, o_overflow=0, o_cycle=0, and the next captured record carries stamp 0.
